// File: rtl/z_stream_ctrl.sv
// z_stream_ctrl: Z-sample buffer sequencer.
// Writes DEPTH whitened 4-channel vectors into the Z buffer, then replays the
// buffer PASSES times toward the iteration unit with valid/last tagging.
// Optional write-underrun detection is enabled by defining ZCTRL_UNDERRUN_CHK_EN.
module z_stream_ctrl #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 26,
    parameter int PASSES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_z1,
    input  logic signed [WIDTH-1:0] in_z2,
    input  logic signed [WIDTH-1:0] in_z3,
    input  logic signed [WIDTH-1:0] in_z4,
    output logic                    ram_go,
    output logic                    ram_rw,
    output logic signed [WIDTH-1:0] ram_z1_in,
    output logic signed [WIDTH-1:0] ram_z2_in,
    output logic signed [WIDTH-1:0] ram_z3_in,
    output logic signed [WIDTH-1:0] ram_z4_in,
    input  logic signed [WIDTH-1:0] ram_z1_out,
    input  logic signed [WIDTH-1:0] ram_z2_out,
    input  logic signed [WIDTH-1:0] ram_z3_out,
    input  logic signed [WIDTH-1:0] ram_z4_out,
    output logic                    out_valid,
    output logic                    out_last,
    output logic signed [WIDTH-1:0] out_z1,
    output logic signed [WIDTH-1:0] out_z2,
    output logic signed [WIDTH-1:0] out_z3,
    output logic signed [WIDTH-1:0] out_z4,
    output logic [3:0]              pass_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_READ,
        S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_pass;
    logic            r_ram_go, r_ram_rw, r_in_ready, r_done;
    logic            r_out_valid, r_out_last;
    logic            w_idx_last, w_pass_last, w_accept;

    assign w_idx_last  = (r_idx == IW'(DEPTH - 1));
    assign w_pass_last = (r_pass == 4'(PASSES - 1));
    assign w_accept    = (r_state == S_IDLE) && start;

    // State register; reset dominates a coincident start.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: one GAP cycle before every read pass drops GO to rewind the buffer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_WRITE;
            S_WRITE: if (w_idx_last) w_next = S_GAP;
            S_GAP:   w_next = S_READ;
            S_READ:  if (w_idx_last) w_next = w_pass_last ? S_DONE : S_GAP;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered decodes, vector index, pass counter and read-latency alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_go    <= 1'b0;
            r_ram_rw    <= 1'b0;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_idx       <= '0;
            r_pass      <= '0;
        end else begin
            r_ram_go    <= (w_next == S_WRITE) || (w_next == S_READ);
            r_ram_rw    <= (w_next == S_WRITE);
            r_in_ready  <= (w_next == S_WRITE);
            r_done      <= (w_next == S_DONE);
            // buffer data lags the READ cycle by one clock
            r_out_valid <= (r_state == S_READ);
            r_out_last  <= (r_state == S_READ) && w_idx_last;
            if ((r_state == S_WRITE) || (r_state == S_READ))
                r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            else
                r_idx <= '0;
            if (w_accept)
                r_pass <= '0;
            else if ((r_state == S_READ) && w_idx_last && !w_pass_last)
                r_pass <= r_pass + 4'd1;
        end
    end

`ifdef ZCTRL_UNDERRUN_CHK_EN
    logic r_underrun;

    // Sticky: any WRITE slot without a presented vector; cleared by a new frame.
    always_ff @(posedge clk) begin
        if (rst)
            r_underrun <= 1'b0;
        else if (w_accept)
            r_underrun <= 1'b0;
        else if ((r_state == S_WRITE) && !in_valid)
            r_underrun <= 1'b1;
    end

    assign underrun = r_underrun;
`else
    logic w_unused_in_valid;
    assign w_unused_in_valid = in_valid;
    assign underrun          = 1'b0;
`endif

    assign ram_go    = r_ram_go;
    assign ram_rw    = r_ram_rw;
    assign in_ready  = r_in_ready;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);
    assign pass_idx  = r_pass;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

    // write data is never stalled: straight through to the buffer
    assign ram_z1_in = in_z1;
    assign ram_z2_in = in_z2;
    assign ram_z3_in = in_z3;
    assign ram_z4_in = in_z4;

    assign out_z1 = ram_z1_out;
    assign out_z2 = ram_z2_out;
    assign out_z3 = ram_z3_out;
    assign out_z4 = ram_z4_out;

endmodule

// File: tb/tb_z_stream_ctrl.sv
// tb_z_stream_ctrl: directed bench with a behavioural Z buffer per instance.
// Small instance (DEPTH=2, PASSES=1) is driven from a vector table; the
// default-sized instance runs full frames against a closed-form schedule.
module tb_z_stream_ctrl;
    localparam int W  = 26;
    localparam int BD = 128;
    localparam int BP = 4;
    localparam int BN = 1 + BD + BP * (1 + BD);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- big instance ----------------
    logic b_start = 1'b0, b_in_valid = 1'b1, b_in_ready;
    logic signed [W-1:0] b_in_z1 = '0, b_in_z2 = '0, b_in_z3 = '0, b_in_z4 = '0;
    logic b_go, b_rw, b_ov, b_ol, b_busy, b_done, b_ur;
    logic signed [W-1:0] b_rzi1, b_rzi2, b_rzi3, b_rzi4;
    logic signed [W-1:0] b_rzo1, b_rzo2, b_rzo3, b_rzo4;
    logic signed [W-1:0] b_oz1, b_oz2, b_oz3, b_oz4;
    logic [3:0] b_pi;

    z_stream_ctrl #(.DEPTH(BD), .WIDTH(W), .PASSES(BP)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_z1(b_in_z1), .in_z2(b_in_z2), .in_z3(b_in_z3), .in_z4(b_in_z4),
        .ram_go(b_go), .ram_rw(b_rw),
        .ram_z1_in(b_rzi1), .ram_z2_in(b_rzi2), .ram_z3_in(b_rzi3), .ram_z4_in(b_rzi4),
        .ram_z1_out(b_rzo1), .ram_z2_out(b_rzo2), .ram_z3_out(b_rzo3), .ram_z4_out(b_rzo4),
        .out_valid(b_ov), .out_last(b_ol),
        .out_z1(b_oz1), .out_z2(b_oz2), .out_z3(b_oz3), .out_z4(b_oz4),
        .pass_idx(b_pi), .busy(b_busy), .done(b_done), .underrun(b_ur)
    );

    // ---------------- small instance ----------------
    logic s_start = 1'b0, s_in_valid = 1'b1, s_in_ready;
    logic signed [W-1:0] s_in_z1 = '0, s_in_z2 = '0, s_in_z3 = '0, s_in_z4 = '0;
    logic s_go, s_rw, s_ov, s_ol, s_busy, s_done, s_ur;
    logic signed [W-1:0] s_rzi1, s_rzi2, s_rzi3, s_rzi4;
    logic signed [W-1:0] s_rzo1, s_rzo2, s_rzo3, s_rzo4;
    logic signed [W-1:0] s_oz1, s_oz2, s_oz3, s_oz4;
    logic [3:0] s_pi;

    z_stream_ctrl #(.DEPTH(2), .WIDTH(W), .PASSES(1)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_z1(s_in_z1), .in_z2(s_in_z2), .in_z3(s_in_z3), .in_z4(s_in_z4),
        .ram_go(s_go), .ram_rw(s_rw),
        .ram_z1_in(s_rzi1), .ram_z2_in(s_rzi2), .ram_z3_in(s_rzi3), .ram_z4_in(s_rzi4),
        .ram_z1_out(s_rzo1), .ram_z2_out(s_rzo2), .ram_z3_out(s_rzo3), .ram_z4_out(s_rzo4),
        .out_valid(s_ov), .out_last(s_ol),
        .out_z1(s_oz1), .out_z2(s_oz2), .out_z3(s_oz3), .out_z4(s_oz4),
        .pass_idx(s_pi), .busy(s_busy), .done(s_done), .underrun(s_ur)
    );

    // ---------------- behavioural Z buffers (GO low rewinds, 1-cycle read) ----------------
    logic [4*W-1:0] b_mem [0:255];
    logic [4*W-1:0] s_mem [0:255];
    logic [7:0]     b_ptr = '0, s_ptr = '0;
    logic [4*W-1:0] b_q = '0, s_q = '0;
    assign {b_rzo4, b_rzo3, b_rzo2, b_rzo1} = b_q;
    assign {s_rzo4, s_rzo3, s_rzo2, s_rzo1} = s_q;

    always @(posedge clk) begin
        if (!b_go) b_ptr <= '0;
        else begin
            if (b_rw) b_mem[b_ptr] <= {b_rzi4, b_rzi3, b_rzi2, b_rzi1};
            else      b_q <= b_mem[b_ptr];
            b_ptr <= b_ptr + 8'd1;
        end
    end

    always @(posedge clk) begin
        if (!s_go) s_ptr <= '0;
        else begin
            if (s_rw) s_mem[s_ptr] <= {s_rzi4, s_rzi3, s_rzi2, s_rzi1};
            else      s_q <= s_mem[s_ptr];
            s_ptr <= s_ptr + 8'd1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // vector k of a frame: z1=v, z2=-v, z3=2v, z4=v+1000 with v=k+off
    function automatic logic [4*W-1:0] dword(input int k, input int off);
        int v;
        v = k + off;
        return {W'(v + 1000), W'(2 * v), W'(-v), W'(v)};
    endfunction

    // Expected big-instance schedule, n = cycles since the start edge.
    function automatic void exp_at(input int n, output logic go, output logic rw,
                                   output logic dn, output logic bs,
                                   output logic [3:0] pi, output int rj);
        int m, p, r;
        go = 1'b0; rw = 1'b0; dn = 1'b0; bs = 1'b0; pi = 4'(BP - 1); rj = -1;
        if (n >= 1 && n <= BD) begin
            go = 1'b1; rw = 1'b1; bs = 1'b1; pi = 4'd0;
        end else if (n > BD && n < BN) begin
            m = n - (BD + 1); p = m / (BD + 1); r = m % (BD + 1);
            bs = 1'b1; pi = 4'(p);
            if (r != 0) begin go = 1'b1; rj = r - 1; end
        end else if (n == BN) begin
            dn = 1'b1; bs = 1'b1;
        end
    endfunction

    task automatic run_big(input int off, input int again_n, input int rst_at, input bit drop);
        logic go, rw, dn, bs, gp, rp, dp, bp;
        logic [3:0] pi, pp;
        int rj, rjp;
        logic exp_ur;
        b_start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= BN + 1; n++) begin
            @(negedge clk);
            exp_at(n, go, rw, dn, bs, pi, rj);
            exp_at(n - 1, gp, rp, dp, bp, pp, rjp);
            if (rst_at > 0 && n == rst_at + 1) begin
                chk("rst_go", b_go, 1'b0);
                chk("rst_ov", b_ov, 1'b0);
                chk("rst_busy_done", {b_busy, b_done, b_pi}, 6'd0);
                break;
            end
            chk("b_ctl", {b_go, b_rw, b_in_ready, b_done, b_busy, b_pi}, {go, rw, rw, dn, bs, pi});
            chk("b_ov_ol", {b_ov, b_ol}, {rjp >= 0, rjp == BD - 1});
            if (rjp >= 0)
                chk("b_data", {b_oz4, b_oz3, b_oz2, b_oz1}, dword(rjp, off));
`ifdef ZCTRL_UNDERRUN_CHK_EN
            exp_ur = drop && (n >= 9);
`else
            exp_ur = 1'b0;
`endif
            chk("b_underrun", b_ur, exp_ur);
            b_start = (n == again_n);
            if (n <= BD) {b_in_z4, b_in_z3, b_in_z2, b_in_z1} = dword(n - 1, off);
            else         {b_in_z4, b_in_z3, b_in_z2, b_in_z1} = '0;
            b_in_valid = !(drop && n == 8);
            if (n == rst_at) rst = 1'b1;
        end
        b_start = 1'b0;
        b_in_valid = 1'b1;
        if (rst_at > 0) begin
            rst = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("post_rst_quiet", {b_go, b_done, b_ov, b_busy}, 4'd0);
            end
        end
    endtask

    // ---------------- small-instance vector table ----------------
    typedef struct {
        logic           start;
        logic [4*W-1:0] din;
        logic           go, rw, rdy, dn, bs;
        logic [3:0]     pi;
        logic           ov, ol;
        logic [4*W-1:0] ez;
    } vec_t;

    vec_t tv [7];

    initial begin
        logic [4*W-1:0] za, zb, zc;
        za = dword(5, 0); zb = dword(7, 0); zc = dword(9, 0);
        //        start din  go   rw   rdy  dn   bs   pi    ov   ol   ez
        tv[0] = '{1'b1, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, '0}; // WRITE0
        tv[1] = '{1'b1, za, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, '0}; // WRITE1, start ignored
        tv[2] = '{1'b0, zb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, '0}; // GAP
        tv[3] = '{1'b1, zc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, '0}; // READ0, start ignored
        tv[4] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, za}; // READ1
        tv[5] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, zb}; // DONE
        tv[6] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, '0}; // IDLE

        // reset, then 10 idle cycles at reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_big", {b_go, b_rw, b_in_ready, b_ov, b_ol, b_done, b_busy, b_pi, b_ur}, '0);
            chk("idle_small", {s_go, s_rw, s_in_ready, s_ov, s_ol, s_done, s_busy, s_pi, s_ur}, '0);
        end

        // DEPTH=2, PASSES=1 frame from the table
        for (int i = 0; i < 7; i++) begin
            s_start = tv[i].start;
            {s_in_z4, s_in_z3, s_in_z2, s_in_z1} = tv[i].din;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("s_ctl[%0d]", i), {s_go, s_rw, s_in_ready, s_done, s_busy, s_pi, s_ur},
                {tv[i].go, tv[i].rw, tv[i].rdy, tv[i].dn, tv[i].bs, tv[i].pi, 1'b0});
            chk($sformatf("s_zin[%0d]", i), {s_rzi4, s_rzi3, s_rzi2, s_rzi1}, tv[i].din);
            chk($sformatf("s_ov_ol[%0d]", i), {s_ov, s_ol}, {tv[i].ov, tv[i].ol});
            if (tv[i].ov)
                chk($sformatf("s_data[%0d]", i), {s_oz4, s_oz3, s_oz2, s_oz1}, tv[i].ez);
        end
        s_start = 1'b0;

        // full frames on the default-sized instance
        run_big(0, 0, 0, 1'b0);                                 // plain frame
        run_big(300, BD + 2 + (BD + 1) + 10, 0, 1'b1);         // start in READ pass 1, in_valid drop at idx 7
        run_big(600, 0, BD + 2 + 2 * (BD + 1) + 50, 1'b0);     // rst at READ idx 50 of pass 2
        run_big(900, 0, 0, 1'b0);                               // full frame after reset

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/z_stream_ctrl.md
# z_stream_ctrl

Sequencer that owns the Z-sample buffer protocol. It streams DEPTH whitened 4-channel Z vectors from the whitening stage into the Z buffer, then replays the buffer PASSES times toward the fixed-point iteration unit, tagging each vector valid and marking the last vector of each pass. It drives the buffer's GO/RW pins and consumes its registered Z outputs, which is the initiator side of the buffer interface.

## Interface
- DEPTH, 128, vectors per frame; equals buffer depth; 2..255
- WIDTH, 26, signed sample width
- PASSES, 4, read passes per frame; 1..15
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle frame request; honoured only in IDLE
- in_valid  in  1  whitening stage presents a vector
- in_ready  out  1  high on every WRITE cycle
- in_z1..in_z4  in  WIDTH each  signed input vector
- ram_go, ram_rw  out  1 each  buffer GO / RW (1 = write)
- ram_z1_in..ram_z4_in  out  WIDTH each  write data to buffer
- ram_z1_out..ram_z4_out  in  WIDTH each  registered buffer read data
- out_valid  out  1  out_z holds a replayed vector
- out_last  out  1  with out_valid: final vector of a pass
- out_z1..out_z4  out  WIDTH each  replayed vector (= ram_z*_out)
- pass_idx  out  4  current read pass, 0-based
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final pass
- underrun  out  1  sticky write-underrun flag (see Configuration)

## Operation
- States: IDLE, WRITE, GAP, READ, DONE.
- IDLE: ram_go=0. start=1 -> WRITE, idx=0, pass_idx=0, underrun cleared.
- WRITE: ram_go=1, ram_rw=1, in_ready=1, ram_z*_in=in_z*. idx increments each cycle; after idx=DEPTH-1 -> GAP.
- GAP: exactly one cycle, ram_go=0 (clears buffer pointer) -> READ, idx=0.
- READ: ram_go=1, ram_rw=0. idx increments; after idx=DEPTH-1: if pass_idx=PASSES-1 -> DONE, else pass_idx+1 and -> GAP.
- DONE: one cycle, done=1, ram_go=0 -> IDLE.
- Buffer pointer never wraps under this controller; GO-low in GAP/DONE/IDLE is the only reset of it.
- Write data is not stalled: buffer writes every WRITE cycle regardless of in_valid.
- start outside IDLE ignored. Simultaneous rst and start: rst wins.
- pass_idx holds its last value through DONE and IDLE until next start.

## Timing
- Reset values: state IDLE, ram_go=0, ram_rw=0, in_ready=0, out_valid=0, out_last=0, done=0, busy=0, pass_idx=0, underrun=0, idx=0.
- ram_go, ram_rw, in_ready, done are registered state decodes; ram_z*_in combinational from in_z*.
- start sampled at edge E -> ram_go=1, ram_rw=1 from E+1 for DEPTH cycles.
- out_valid is the READ-cycle indicator delayed one cycle (buffer read latency 1); out_last is idx=DEPTH-1 in READ delayed one cycle. out_valid never high during or one cycle after a WRITE cycle (buffer echo ignored).
- Frame length from start to done: 1 + DEPTH + PASSES*(1+DEPTH) cycles in FSM, done in last; final out_valid coincides with the DONE cycle.
- rst mid-frame: next cycle ram_go=0, out_valid=0; the truncated frame produces no done.

## Configuration
- ZCTRL_UNDERRUN_CHK_EN defined: any WRITE cycle with in_valid=0 sets underrun; it stays set until next accepted start or rst; the slot is still written with current in_z*.
- Not defined: in_valid ignored, underrun tied 0.

## Test plan
- Reset then idle 10 cycles -> all outputs at reset values, ram_go=0 throughout.
- DEPTH=128, PASSES=4, in_z1=k, in_z2=-k, in_z3=2k, in_z4=k+1000 for k=0..127 -> 4 passes of 128 out_valid vectors, values match per k, out_last on k=127, pass_idx 0..3, done at 1+128+4*129 cycles after start edge.
- start pulsed again during READ pass 1 -> ignored, frame completes unchanged, single done.
- rst asserted at READ idx=50 of pass 2 -> ram_go=0 and out_valid=0 next cycle, no done; new start then produces full correct frame.
- With ZCTRL_UNDERRUN_CHK_EN, in_valid low at WRITE idx=7 -> underrun=1 through DONE, cleared at next start; without the macro underrun stays 0.
- PASSES=1, DEPTH=2 -> out_valid high exactly 2 cycles, done 6 cycles after start edge.
